aes_in_loader: RTL
==================

# aes_in_loader

Upstream feeder for `AES_top`. It accepts plaintext and key as 32-bit words over a valid/ready stream and assembles them MSB-first into the 128-bit `AES_data_in` and `AES_key_in` buses. It then holds `AES_en` high until the core reports `AES_data_out_valid`, or until a timeout expires. The key persists across blocks, so multiple plaintexts can be encrypted under one key load.

## Interface
- `TIMEOUT`, default 64: maximum number of RUN cycles to wait for `AES_data_out_valid`. Legal range is ≥ 2.
- `AES_clk` in 1: single clock; all logic is rising-edge.
- `AES_rst` in 1: reset, synchronous and active-high.
- `s_word` in 32: input word.
- `s_valid` in 1: `s_word` is valid.
- `s_is_key` in 1: 1 means the word is a key word; 0 means it is a plaintext word. Qualified by `s_valid`.
- `s_ready` out 1: the word is accepted on a clock edge where `s_valid && s_ready`.
- `AES_en` out 1: enable to `AES_top`; registered.
- `AES_data_in` out 128: plaintext to the core; registered.
- `AES_key_in` out 128: key to the core; registered.
- `AES_data_out_valid` in 1: completion strobe from `AES_top`.
- `busy` out 1: high while in RUN.
- `timeout` out 1: one-cycle pulse when RUN is aborted by timeout.

## Operation
- **States:** LOAD and RUN. Reset enters LOAD.
- **Word shifting:**
  - An accepted data word does `AES_data_in <= {AES_data_in[95:0], s_word}` and increments `dcnt` (0..4).
  - An accepted key word does the same on `AES_key_in` with `kcnt`.
  - After 4 words, the first word sits in bits [127:96].
- **Key status:**
  - `key_ok` sets when `kcnt` reaches 4.
  - Any key word accepted while `key_ok=1` clears `key_ok`, sets `kcnt=1`, and shifts the word in. This is a key reload.
- **LOAD state:**
  - `s_ready=1`, except when `dcnt==4 && !key_ok`. In that case `s_ready=s_is_key`, a combinational path: further data words are stalled, key words are still accepted.
- **LOAD → RUN** at the edge where `dcnt` would become 4 (or already is 4) and `key_ok` is, or becomes, 1:
  - `AES_en<=1`, `dcnt<=0`, cycle counter `tcnt<=0`.
- **RUN state:**
  - `s_ready=0`.
  - `AES_data_in` and `AES_key_in` are frozen.
  - `tcnt` increments each cycle.
- **RUN → LOAD on completion:** at the first edge where `AES_data_out_valid=1`, set `AES_en<=0`.
- **RUN → LOAD on timeout:** at the edge where `tcnt==TIMEOUT-1` and valid is 0, set `AES_en<=0` and `timeout<=1` for one cycle.
- **Simultaneous events:** valid and the timeout condition on the same edge count as completion; no `timeout` pulse.
- **Spurious valid:** `AES_data_out_valid` while in LOAD is ignored.

## Timing
- **Reset:**
  - While `AES_rst` is high, `s_ready=0`.
  - After the reset edge: `AES_en=0`, `AES_data_in=0`, `AES_key_in=0`, `busy=0`, `timeout=0`, `dcnt=kcnt=0`, `key_ok=0`, state LOAD.
- **Latency:** `AES_en` is high in the cycle immediately after the accepting edge of the 4th data word (or of the 4th key word, when data was already full).
- **Output stability:** `AES_data_in` and `AES_key_in` are stable from that edge until `AES_en` falls.
- **Release:** `AES_en` falls one cycle after valid is sampled. `s_ready` returns to 1 in the same cycle.
- **Throughput:** minimum 4 cycles between blocks for data load, plus the core latency.
- **Reset mid-RUN:** state returns to LOAD, `AES_en` drops the next cycle, and the key is lost.

## Structure
- Package `aes_pkg`:
  - `AES_BLK_W=128`, `AES_WORD_W=32`.
  - `typedef enum logic {LOAD, RUN} aes_ld_state_t`.
- Sub-module `aes_word_shift128`: 4-word shift register with a 0..4 counter, a `clr`/restart input and a full flag. It is instantiated twice, once for data and once for key.
- Top level holds the FSM, `tcnt` (width `$clog2(TIMEOUT)`) and the `key_ok` logic.

## Test plan
1. **Basic block:** load key words aa2bdb40, bff6a5e8, caa9ba3e, bc1e2acc, then data 00000041, 0, 0, 0.
   - Expect `AES_key_in=aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc` and `AES_data_in=00000041_00000000_00000000_00000000`.
   - Expect `AES_en` high the cycle after the 4th data word, and low one cycle after a stub raises valid at cycle 50.
2. **Data before key:** send 4 data words, then a 5th data word with `s_valid` held.
   - Expect `s_ready=0` for the data word, `AES_en` stays 0.
   - After the 4 key words, `AES_en` rises the next cycle.
3. **Key reuse:** after test 1, send data a6f2daeb, 140fa720, 529e75d5, 21cbc681.
   - Expect RUN with the key unchanged and no key words sent.
4. **Timeout:** `TIMEOUT=8`, stub never raises valid.
   - Expect `AES_en` high for exactly 8 cycles, a one-cycle `timeout` pulse, `s_ready=1` afterwards.
   - Also drive valid at `tcnt=7`: expect no `timeout` pulse.
5. **Reset mid-RUN:** assert `AES_rst` for 1 cycle during RUN.
   - Expect `AES_en=0` and both buses 0.
   - Next block waits for a fresh key (`key_ok=0`).
6. **Key reload:** with `key_ok=1`, send one key word 11111111.
   - Expect `key_ok` cleared and 4 data words not starting RUN until 3 more key words arrive.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared widths and state type for the AES input loader.
// Contents: block/word widths, word count per block, fill-counter width,
// and the LOAD/RUN state encoding.
package aes_pkg;

    localparam int unsigned AES_BLK_W  = 128;
    localparam int unsigned AES_WORD_W = 32;
    localparam int unsigned AES_WORDS  = AES_BLK_W / AES_WORD_W;
    localparam int unsigned AES_CNT_W  = $clog2(AES_WORDS + 1);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } aes_ld_state_t;

endpackage

// File: rtl/aes_word_shift128.sv
// Four-word MSB-first shift register with a 0..4 fill counter.
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   shift         - shift word into the low end, advance the counter
//   restart       - with shift: counter restarts at 1 (fresh load)
//   clr           - counter back to 0, contents kept
//   word          - incoming 32-bit word
//   blk           - assembled 128-bit block (first word ends in [127:96])
//   full          - counter is 4
//   full_nxt_c    - counter will be 4 after this edge, ignoring clr
module aes_word_shift128
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift,
    input  logic                  restart,
    input  logic                  clr,
    input  logic [AES_WORD_W-1:0] word,
    output logic [AES_BLK_W-1:0]  blk,
    output logic                  full,
    output logic                  full_nxt_c
);

    logic [AES_BLK_W-1:0] blk_q, blk_d;
    logic [AES_CNT_W-1:0] cnt_q, cnt_d;
    logic [AES_CNT_W-1:0] cnt_adv;

    // Fill count after this edge's shift, before any clear.
    always_comb begin
        cnt_adv = cnt_q;
        if (shift) begin
            cnt_adv = restart ? AES_CNT_W'(1) : cnt_q + AES_CNT_W'(1);
        end
    end

    assign full_nxt_c = (cnt_adv == AES_CNT_W'(AES_WORDS));

    // Kept apart from cnt_adv so clr (which depends on full_nxt_c) forms no loop.
    always_comb begin
        blk_d = blk_q;
        cnt_d = clr ? '0 : cnt_adv;
        if (shift) begin
            blk_d = {blk_q[AES_BLK_W-AES_WORD_W-1:0], word};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
            cnt_q <= '0;
        end else begin
            blk_q <= blk_d;
            cnt_q <= cnt_d;
        end
    end

    assign blk  = blk_q;
    assign full = (cnt_q == AES_CNT_W'(AES_WORDS));

endmodule

// File: rtl/aes_in_loader.sv
// Feeds AES_top: assembles plaintext and key words into 128-bit buses, then
// holds AES_en until the core signals completion or TIMEOUT cycles elapse.
// The key survives across blocks until reset or a key reload.
// Ports:
//   AES_clk, AES_rst      - clock, synchronous active-high reset
//   s_word/s_valid/s_ready/s_is_key - 32-bit input word stream
//   AES_en, AES_data_in, AES_key_in  - registered core inputs
//   AES_data_out_valid    - completion strobe from the core
//   busy                  - high while running
//   timeout               - one-cycle pulse when a run is abandoned
module aes_in_loader
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  AES_clk,
    input  logic                  AES_rst,
    input  logic [AES_WORD_W-1:0] s_word,
    input  logic                  s_valid,
    input  logic                  s_is_key,
    output logic                  s_ready,
    output logic                  AES_en,
    output logic [AES_BLK_W-1:0]  AES_data_in,
    output logic [AES_BLK_W-1:0]  AES_key_in,
    input  logic                  AES_data_out_valid,
    output logic                  busy,
    output logic                  timeout
);

    localparam int unsigned      TCNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    aes_ld_state_t     state_q, state_d;
    logic              en_q, en_d;
    logic              to_q, to_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;

    logic accept;
    logic d_shift, k_shift;
    logic d_full, d_full_nxt;
    logic k_full, k_full_nxt;
    logic d_clr;
    logic go_run;

    // Data words stall once data is full and the key is incomplete; key words never stall in LOAD.
    assign s_ready = !AES_rst && (state_q == LOAD) && (!(d_full && !k_full) || s_is_key);

    assign accept  = s_valid && s_ready;
    assign d_shift = accept && !s_is_key;
    assign k_shift = accept && s_is_key;
    assign go_run  = (state_q == LOAD) && d_full_nxt && k_full_nxt;

    aes_word_shift128 u_data (
        .clk        (AES_clk),
        .rst        (AES_rst),
        .shift      (d_shift),
        .restart    (1'b0),
        .clr        (d_clr),
        .word       (s_word),
        .blk        (AES_data_in),
        .full       (d_full),
        .full_nxt_c (d_full_nxt)
    );

    // A key word arriving while the key is complete starts a reload.
    aes_word_shift128 u_key (
        .clk        (AES_clk),
        .rst        (AES_rst),
        .shift      (k_shift),
        .restart    (k_full),
        .clr        (1'b0),
        .word       (s_word),
        .blk        (AES_key_in),
        .full       (k_full),
        .full_nxt_c (k_full_nxt)
    );

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        to_d    = 1'b0;
        tcnt_d  = tcnt_q;
        d_clr   = 1'b0;
        if (state_q == LOAD) begin
            if (go_run) begin
                state_d = RUN;
                en_d    = 1'b1;
                tcnt_d  = '0;
                d_clr   = 1'b1;
            end
        end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            // Completion wins over a coincident timeout.
            if (AES_data_out_valid) begin
                state_d = LOAD;
                en_d    = 1'b0;
            end else if (tcnt_q == TCNT_LAST) begin
                state_d = LOAD;
                en_d    = 1'b0;
                to_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_q <= LOAD;
            en_q    <= 1'b0;
            to_q    <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            to_q    <= to_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign AES_en  = en_q;
    assign timeout = to_q;
    assign busy    = (state_q == RUN);

endmodule
